// File: rtl/axis_rx_pkg.sv
// rtl/axis_rx_pkg.sv - shared constants and byte-masking helper for the AXIS receive endpoint
package axis_rx_pkg;

    localparam int N_BYTES   = 4;
    localparam int MAX_BYTES = 128;

    // Works on a maximum-width lane set; callers zero-pad and truncate to their own width.
    function automatic logic [8*MAX_BYTES-1:0] mask_bytes(
        input logic [8*MAX_BYTES-1:0] tdata,
        input logic [MAX_BYTES-1:0]   tkeep,
        input logic [MAX_BYTES-1:0]   tstrb
    );
        logic [8*MAX_BYTES-1:0] result;
        result = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (tkeep[i] && tstrb[i]) begin
                result[8*i +: 8] = tdata[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_slave_rx_if.sv
// rtl/axis_slave_rx_if.sv - upstream AXIS beat signals plus downstream valid/available handoff
interface axis_slave_rx_if #(
    parameter int n = 4
);
    logic           tready;
    logic           tvalid;
    logic [8*n-1:0] tdata;
    logic [n-1:0]   tstrb;
    logic [n-1:0]   tkeep;
    logic           tlast;
    logic           TID;
    logic           TDEST;
    logic           TUSER;
    logic           buf_available;
    logic [8*n-1:0] data;
    logic           d_valid;
    logic           last_data;

    modport slave (
        output tready,
        input  tvalid, tdata, tstrb, tkeep, tlast, TID, TDEST, TUSER,
        input  buf_available,
        output data, d_valid, last_data
    );

    modport master (
        input  tready,
        output tvalid, tdata, tstrb, tkeep, tlast, TID, TDEST, TUSER,
        output buf_available,
        input  data, d_valid, last_data
    );
endinterface

// File: rtl/axis_skid_buffer.sv
// rtl/axis_skid_buffer.sv - two-entry register slice (output register + skid) with registered in_ready
module axis_skid_buffer #(
    parameter int WIDTH = 33
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic             accept;
    logic             load_out;

    assign accept   = in_valid && in_ready;
    assign load_out = !out_valid || out_ready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b0;
        end else if (load_out) begin
            if (skid_valid) begin
                // Older skid beat moves forward first so ordering is preserved.
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= accept;
                if (accept) begin
                    skid_data <= in_data;
                end
                in_ready   <= !accept;
            end else begin
                out_valid <= accept;
                if (accept) begin
                    out_data <= in_data;
                end
                in_ready  <= 1'b1;
            end
        end else begin
            if (accept) begin
                skid_data  <= in_data;
                skid_valid <= 1'b1;
            end
            in_ready <= !(skid_valid || accept);
        end
    end

endmodule

// File: rtl/axis_slave_rx.sv
// rtl/axis_slave_rx.sv - AXIS slave receive endpoint: byte masking into a skid-buffered valid/available output
module axis_slave_rx
    import axis_rx_pkg::*;
#(
    parameter int n = N_BYTES
) (
    input  logic                aclk,
    input  logic                aresetn,
    axis_slave_rx_if.slave      bus
);

    logic [8*MAX_BYTES-1:0] wide_data;
    logic [MAX_BYTES-1:0]   wide_keep;
    logic [MAX_BYTES-1:0]   wide_strb;
    logic [8*n-1:0]         masked;
    logic [8*n:0]           out_beat;
    logic                   unused_sideband;

    // Routing and sideband fields are accepted on the bus but carry no meaning here.
    assign unused_sideband = ^{bus.TID, bus.TDEST, bus.TUSER};

    always_comb begin
        wide_data = '0;
        wide_keep = '0;
        wide_strb = '0;
        wide_data[8*n-1:0] = bus.tdata;
        wide_keep[n-1:0]   = bus.tkeep;
        wide_strb[n-1:0]   = bus.tstrb;
    end

    assign masked = (8*n)'(mask_bytes(wide_data, wide_keep, wide_strb));

    axis_skid_buffer #(
        .WIDTH (8*n + 1)
    ) u_skid (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_data   ({masked, bus.tlast}),
        .in_valid  (bus.tvalid),
        .in_ready  (bus.tready),
        .out_data  (out_beat),
        .out_valid (bus.d_valid),
        .out_ready (bus.buf_available)
    );

    assign bus.data      = out_beat[8*n:1];
    assign bus.last_data = out_beat[0];

endmodule

// File: tb/tb_axis_slave_rx.sv
// tb/tb_axis_slave_rx.sv - directed self-checking bench for axis_slave_rx
module tb_axis_slave_rx;

    logic aclk;
    logic aresetn;
    int   checks;
    int   errors;
    int   cnt;
    int   exp_d;
    int   e_held;
    bit   counting;
    bit   hs;

    axis_slave_rx_if #(.n(4)) bus ();

    axis_slave_rx #(.n(4)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus.slave)
    );

    initial aclk = 1'b1;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; the counting master advances its payload only on a handshake edge.
    task automatic cycle();
        hs = bus.tvalid && bus.tready;
        @(posedge aclk);
        #1;
        if (hs && counting) begin
            cnt++;
            bus.tdata = 32'(cnt);
            bus.tlast = (cnt == 32);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        counting = 0;
        cnt = 0;
        aresetn = 1'b0;
        bus.tvalid = 1'b0;
        bus.tdata = '0;
        bus.tstrb = 4'hF;
        bus.tkeep = 4'hF;
        bus.tlast = 1'b0;
        bus.TID = 1'b0;
        bus.TDEST = 1'b0;
        bus.TUSER = 1'b0;
        bus.buf_available = 1'b0;

        #45;
        check("rst_tready", 32'(bus.tready), 32'd0);
        check("rst_d_valid", 32'(bus.d_valid), 32'd0);
        check("rst_data", bus.data, 32'd0);
        check("rst_last", 32'(bus.last_data), 32'd0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check("post_rst_tready", 32'(bus.tready), 32'd1);

        // Stall fill
        counting = 1;
        cnt = 1;
        bus.tdata = 32'd1;
        bus.tvalid = 1'b1;
        cycle();
        check("fill1_data", bus.data, 32'd1);
        check("fill1_valid", 32'(bus.d_valid), 32'd1);
        check("fill1_tready", 32'(bus.tready), 32'd1);
        cycle();
        check("fill2_data", bus.data, 32'd1);
        check("fill2_tready", 32'(bus.tready), 32'd0);
        cycle();
        check("fill3_data", bus.data, 32'd1);
        check("fill3_tready", 32'(bus.tready), 32'd0);
        check("fill3_tdata_held", bus.tdata, 32'd3);

        // Continuous stream
        bus.buf_available = 1'b1;
        cycle();
        check("drain_data", bus.data, 32'd2);
        check("drain_tready", 32'(bus.tready), 32'd1);
        exp_d = 3;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("stream_data", bus.data, 32'(exp_d));
            check("stream_valid", 32'(bus.d_valid), 32'd1);
            check("stream_last", 32'(bus.last_data), 32'd0);
            exp_d++;
        end

        // Stall mid-stream, then resume
        e_held = exp_d - 1;
        bus.buf_available = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("stall_data", bus.data, 32'(e_held));
            check("stall_tready", 32'(bus.tready), 32'd0);
        end
        bus.buf_available = 1'b1;
        cycle();
        check("resume_data", bus.data, 32'(e_held + 1));
        check("resume_tready", 32'(bus.tready), 32'd1);
        exp_d = e_held + 2;
        for (int i = 0; i < 40 && exp_d <= 36; i++) begin
            cycle();
            check("resume_stream_data", bus.data, 32'(exp_d));
            check("resume_stream_valid", 32'(bus.d_valid), 32'd1);
            check("tlast_data", 32'(bus.last_data), 32'(exp_d == 32));
            exp_d++;
        end
        check("stream_reached_end", 32'(exp_d), 32'd37);

        // Masking
        counting = 0;
        bus.tdata = 32'hAABBCCDD;
        bus.tkeep = 4'b1011;
        bus.tstrb = 4'b1110;
        bus.tlast = 1'b0;
        cycle();
        check("mask_data", bus.data, 32'hAA00CC00);
        check("mask_last", 32'(bus.last_data), 32'd0);

        // All-null beat still carries tlast
        bus.tdata = 32'hFFFFFFFF;
        bus.tkeep = 4'h0;
        bus.tstrb = 4'hF;
        bus.tlast = 1'b1;
        cycle();
        check("null_data", bus.data, 32'd0);
        check("null_last", 32'(bus.last_data), 32'd1);
        check("null_valid", 32'(bus.d_valid), 32'd1);
        bus.tvalid = 1'b0;
        bus.tlast = 1'b0;
        cycle();
        check("idle_valid", 32'(bus.d_valid), 32'd0);

        // Reset mid-stream with both entries occupied
        bus.tkeep = 4'hF;
        bus.tdata = 32'h55;
        bus.tvalid = 1'b1;
        bus.buf_available = 1'b0;
        cycle();
        cycle();
        check("pre_rst_full", 32'(bus.tready), 32'd0);
        #3;
        aresetn = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.d_valid), 32'd0);
        check("mid_rst_data", bus.data, 32'd0);
        check("mid_rst_tready", 32'(bus.tready), 32'd0);
        bus.tvalid = 1'b0;
        #3;
        aresetn = 1'b1;
        cycle();
        check("rerst_tready", 32'(bus.tready), 32'd1);
        check("rerst_valid", 32'(bus.d_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
